id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode pipeline stage of the five-stage MIPS core. It latches the fetched instruction, drives the register-file read addresses and consumes the returned operands, and forwards results from EX/MEM/WB. It detects load-use hazards, resolves branches and jumps, and hands a decoded micro-op to EX over a valid/allowin handshake. It sits directly upstream of `registers` (read side) and downstream of the fetch stage.

## Interface
- No parameters; all widths are fixed (MIPS32).
- `clk`  in  1  rising-edge clock
- `resetn`  in  1  asynchronous, active-low reset
- `fs_to_ds_valid`  in  1  fetch offers an instruction
- `fs_pc` / `fs_inst`  in  32/32  PC and instruction word of the offered instruction
- `ds_allowin`  out  1  ID accepts this cycle
- `raddr1` / `raddr2`  out  5/5  register-file read addresses (rs/rt)
- `rdata1` / `rdata2`  in  32/32  register-file read data, combinational
- `es_fwd_valid`, `es_fwd_dest[4:0]`, `es_fwd_data[31:0]`, `es_is_load`  in  EX bypass bus
- `ms_fwd_valid`, `ms_fwd_dest[4:0]`, `ms_fwd_data[31:0]`  in  MEM bypass bus
- `ws_fwd_valid`, `ws_fwd_dest[4:0]`, `ws_fwd_data[31:0]`  in  WB bypass bus
- `es_allowin`  in  1  EX accepts this cycle
- `ds_to_es_valid`  out  1  decoded op offered to EX
- `ds_pc`  out  32  PC of the held instruction
- `ds_alu_op`  out  4  0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SLT, 6 SLL, 7 PASS-src2
- `ds_src1` / `ds_src2`  out  32/32  ALU operands
- `ds_store_data`  out  32  forwarded rt value for SW
- `ds_mem_re` / `ds_mem_we`  out  1/1  LW / SW
- `ds_dest`  out  5  destination register; 0 means no write
- `br_taken` / `br_target`  out  1/32  redirect to fetch

## Operation
- Pipeline register: `ds_valid`, `ds_pc`, `ds_inst`.
  - Loaded when `fs_to_ds_valid && ds_allowin`.
  - `ds_valid` clears when the op leaves without a new one arriving.
- Handshake signals:
  - `ds_ready_go = !load_use`.
  - `ds_allowin = !ds_valid || (ds_ready_go && es_allowin)`.
  - `ds_to_es_valid = ds_valid && ds_ready_go`.
- Read addresses: `raddr1 = inst[25:21]` and `raddr2 = inst[20:16]` from `ds_inst`.
- Supported instructions:
  - ADDU, SUBU, AND, OR, XOR, SLT, SLL: dest = rd.
  - ADDIU, LUI, LW: dest = rt.
  - SW, BEQ, BNE, J: dest = 0.
  - Any other encoding decodes as NOP: ADD, dest 0, no memory access, no branch.
- Immediates:
  - ADDIU/LW/SW: src2 = sign-extended imm16, op ADD.
  - LUI: src2 = {imm16, 16'h0}, op PASS.
  - SLL: src1 = rt value, src2 = zero-extended shamt.
- Operand selection, per source:
  - Register 0 always yields 0 and never forwards.
  - Otherwise priority is ES > MS > WS > `rdataN`.
  - A stage matches when its valid is high and its dest equals the source register.
- Source usage:
  - rs is used by all instructions except J, LUI and SLL.
  - rt is used by R-type, SW, BEQ and BNE.
- `load_use` = `ds_valid && es_fwd_valid && es_is_load && es_fwd_dest != 0 && es_fwd_dest` matches a used source.
- Branches are resolved in ID using forwarded values; the delay slot always executes, so there is no flush.
  - BEQ/BNE target = `ds_pc + 4 + (sext(imm16) << 2)`.
  - J target = `{pc4[31:28], idx26, 2'b00}`.
- `br_taken = ds_to_es_valid && es_allowin && (branch condition true)`. It is asserted only in the cycle the branch transfers to EX.

## Timing
- Reset values:
  - `ds_valid = 0`, `ds_pc = 0`, `ds_inst = 0` (a NOP).
  - Consequently `ds_allowin = 1`, `ds_to_es_valid = 0`, `br_taken = 0`, `ds_mem_re = ds_mem_we = 0`, `ds_dest = 0`.
  - Reset mid-stall discards the held op immediately.
- Latency: one cycle from fetch handshake to `ds_to_es_valid`. All outputs other than the pipeline register are combinational from it.
- Load-use stall: exactly one cycle per hazard. The next cycle the load is in MEM and is forwarded from the MS bus.
- `es_allowin = 0`: `ds_pc`, `ds_inst` and all outputs hold stable, and `ds_allowin = 0`.
- Simultaneous leave and arrive: the new instruction is loaded and `ds_valid` stays 1.

## Test plan
- Reset with `resetn = 0` mid-stream → `ds_to_es_valid = 0` and `ds_allowin = 1` immediately, regardless of `clk`.
- ADDU $3,$1,$2 with `rdata1 = 5` and EX forwarding $2 = 7 → `ds_src1 = 5`, `ds_src2 = 7`, `ds_alu_op = 0`, `ds_dest = 3`.
- LW $4 in EX followed by ADDU $5,$4,$4 → one cycle with `ds_to_es_valid = 0` and `ds_allowin = 0`; next cycle `src1 = src2 =` MS data.
- BEQ at PC 0x100 with imm 0x0004 and equal operands → `br_taken = 1`, `br_target = 0x114`; with unequal operands → `br_taken = 0`.
- `es_allowin = 0` for 3 cycles while holding ORI-free XOR → outputs stable and no new fetch accepted; on release the op passes in 1 cycle.
- Writes targeting $0 on all three bypass buses with source $0 → operand = 0, no stall.

Source files
------------

// File: rtl/id_stage_if.sv
// Signal bundle between the decode stage and its neighbours: fetch, register file, bypass buses and EX.
// The slave modport is the decode stage's view. The master modport is the surrounding pipeline's view.
`timescale 1ns/1ps
interface id_stage_if;
    logic        fs_to_ds_valid;
    logic [31:0] fs_pc;
    logic [31:0] fs_inst;
    logic        ds_allowin;
    logic [4:0]  raddr1;
    logic [4:0]  raddr2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic        es_fwd_valid;
    logic [4:0]  es_fwd_dest;
    logic [31:0] es_fwd_data;
    logic        es_is_load;
    logic        ms_fwd_valid;
    logic [4:0]  ms_fwd_dest;
    logic [31:0] ms_fwd_data;
    logic        ws_fwd_valid;
    logic [4:0]  ws_fwd_dest;
    logic [31:0] ws_fwd_data;
    logic        es_allowin;
    logic        ds_to_es_valid;
    logic [31:0] ds_pc;
    logic [3:0]  ds_alu_op;
    logic [31:0] ds_src1;
    logic [31:0] ds_src2;
    logic [31:0] ds_store_data;
    logic        ds_mem_re;
    logic        ds_mem_we;
    logic [4:0]  ds_dest;
    logic        br_taken;
    logic [31:0] br_target;

    // Handshakes: a transfer happens on a rising edge where the producer's valid and
    // the consumer's allowin are both high; valid never depends on allowin of the same edge.
    modport slave (
        input  fs_to_ds_valid, fs_pc, fs_inst, rdata1, rdata2,
        input  es_fwd_valid, es_fwd_dest, es_fwd_data, es_is_load,
        input  ms_fwd_valid, ms_fwd_dest, ms_fwd_data,
        input  ws_fwd_valid, ws_fwd_dest, ws_fwd_data, es_allowin,
        output ds_allowin, raddr1, raddr2, ds_to_es_valid, ds_pc, ds_alu_op,
        output ds_src1, ds_src2, ds_store_data, ds_mem_re, ds_mem_we, ds_dest,
        output br_taken, br_target
    );

    modport master (
        output fs_to_ds_valid, fs_pc, fs_inst, rdata1, rdata2,
        output es_fwd_valid, es_fwd_dest, es_fwd_data, es_is_load,
        output ms_fwd_valid, ms_fwd_dest, ms_fwd_data,
        output ws_fwd_valid, ws_fwd_dest, ws_fwd_data, es_allowin,
        input  ds_allowin, raddr1, raddr2, ds_to_es_valid, ds_pc, ds_alu_op,
        input  ds_src1, ds_src2, ds_store_data, ds_mem_re, ds_mem_we, ds_dest,
        input  br_taken, br_target
    );
endinterface

// File: rtl/id_stage.sv
// MIPS32 decode stage: holds one instruction, decodes it and selects operands via the EX/MEM/WB bypass buses.
// It stalls one cycle on load-use and resolves branches and jumps before handing the op to EX.
`timescale 1ns/1ps
module id_stage (
    input  logic      clk,
    input  logic      resetn,
    id_stage_if.slave ds
);
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_LUI     = 6'h0f;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_SW      = 6'h2b;
    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_SLT     = 6'h2a;
    localparam logic [3:0] ALU_ADD    = 4'd0;
    localparam logic [3:0] ALU_SUB    = 4'd1;
    localparam logic [3:0] ALU_AND    = 4'd2;
    localparam logic [3:0] ALU_OR     = 4'd3;
    localparam logic [3:0] ALU_XOR    = 4'd4;
    localparam logic [3:0] ALU_SLT    = 4'd5;
    localparam logic [3:0] ALU_SLL    = 4'd6;
    localparam logic [3:0] ALU_PASS   = 4'd7;

    logic        ds_valid_q, ds_valid_d;
    logic [31:0] ds_pc_q, ds_pc_d;
    logic [31:0] ds_inst_q, ds_inst_d;

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] imm16;
    logic [25:0] idx26;

    assign opcode = ds_inst_q[31:26];
    assign rs     = ds_inst_q[25:21];
    assign rt     = ds_inst_q[20:16];
    assign rd     = ds_inst_q[15:11];
    assign shamt  = ds_inst_q[10:6];
    assign funct  = ds_inst_q[5:0];
    assign imm16  = ds_inst_q[15:0];
    assign idx26  = ds_inst_q[25:0];

    logic       is_r3, is_sll, is_addiu, is_lui, is_lw, is_sw, is_beq, is_bne, is_j;
    logic [3:0] r3_op;

    always_comb begin
        is_r3    = 1'b0;
        is_sll   = 1'b0;
        is_addiu = 1'b0;
        is_lui   = 1'b0;
        is_lw    = 1'b0;
        is_sw    = 1'b0;
        is_beq   = 1'b0;
        is_bne   = 1'b0;
        is_j     = 1'b0;
        r3_op    = ALU_ADD;
        case (opcode)
            OP_SPECIAL: begin
                case (funct)
                    FN_SLL:  is_sll = 1'b1;
                    FN_ADDU: begin is_r3 = 1'b1; r3_op = ALU_ADD; end
                    FN_SUBU: begin is_r3 = 1'b1; r3_op = ALU_SUB; end
                    FN_AND:  begin is_r3 = 1'b1; r3_op = ALU_AND; end
                    FN_OR:   begin is_r3 = 1'b1; r3_op = ALU_OR;  end
                    FN_XOR:  begin is_r3 = 1'b1; r3_op = ALU_XOR; end
                    FN_SLT:  begin is_r3 = 1'b1; r3_op = ALU_SLT; end
                    default: ;
                endcase
            end
            OP_J:     is_j     = 1'b1;
            OP_BEQ:   is_beq   = 1'b1;
            OP_BNE:   is_bne   = 1'b1;
            OP_ADDIU: is_addiu = 1'b1;
            OP_LUI:   is_lui   = 1'b1;
            OP_LW:    is_lw    = 1'b1;
            OP_SW:    is_sw    = 1'b1;
            default:  ;
        endcase
    end

    logic is_rtype, rs_used, rt_used;
    assign is_rtype = is_r3 | is_sll;
    assign rs_used  = is_r3 | is_addiu | is_lw | is_sw | is_beq | is_bne;
    assign rt_used  = is_rtype | is_sw | is_beq | is_bne;

    // Youngest producer wins; $0 is hardwired and never bypassed.
    logic [31:0] rs_val, rt_val;
    assign rs_val = (rs == 5'd0) ? 32'd0 :
                    (ds.es_fwd_valid && ds.es_fwd_dest == rs) ? ds.es_fwd_data :
                    (ds.ms_fwd_valid && ds.ms_fwd_dest == rs) ? ds.ms_fwd_data :
                    (ds.ws_fwd_valid && ds.ws_fwd_dest == rs) ? ds.ws_fwd_data :
                    ds.rdata1;
    assign rt_val = (rt == 5'd0) ? 32'd0 :
                    (ds.es_fwd_valid && ds.es_fwd_dest == rt) ? ds.es_fwd_data :
                    (ds.ms_fwd_valid && ds.ms_fwd_dest == rt) ? ds.ms_fwd_data :
                    (ds.ws_fwd_valid && ds.ws_fwd_dest == rt) ? ds.ws_fwd_data :
                    ds.rdata2;

    logic load_use, ready_go, allowin, to_es_valid;
    assign load_use = ds_valid_q && ds.es_fwd_valid && ds.es_is_load && (ds.es_fwd_dest != 5'd0) &&
                      ((rs_used && ds.es_fwd_dest == rs) || (rt_used && ds.es_fwd_dest == rt));
    assign ready_go    = !load_use;
    assign allowin     = !ds_valid_q || (ready_go && ds.es_allowin);
    assign to_es_valid = ds_valid_q && ready_go;

    logic [3:0]  alu_op;
    logic [31:0] src2;
    always_comb begin
        alu_op = ALU_ADD;
        if (is_r3)       alu_op = r3_op;
        else if (is_sll) alu_op = ALU_SLL;
        else if (is_lui) alu_op = ALU_PASS;
    end

    always_comb begin
        src2 = rt_val;
        if (is_sll)                        src2 = {27'd0, shamt};
        else if (is_addiu | is_lw | is_sw) src2 = {{16{imm16[15]}}, imm16};
        else if (is_lui)                   src2 = {imm16, 16'h0000};
    end

    logic [31:0] pc4, br_offset;
    logic        br_cond;
    assign pc4       = ds_pc_q + 32'd4;
    assign br_offset = {{14{imm16[15]}}, imm16, 2'b00};
    assign br_cond   = (is_beq && rs_val == rt_val) || (is_bne && rs_val != rt_val) || is_j;

    assign ds.ds_allowin     = allowin;
    assign ds.raddr1         = rs;
    assign ds.raddr2         = rt;
    assign ds.ds_to_es_valid = to_es_valid;
    assign ds.ds_pc          = ds_pc_q;
    assign ds.ds_alu_op      = alu_op;
    assign ds.ds_src1        = is_sll ? rt_val : rs_val;
    assign ds.ds_src2        = src2;
    assign ds.ds_store_data  = rt_val;
    assign ds.ds_mem_re      = is_lw;
    assign ds.ds_mem_we      = is_sw;
    assign ds.ds_dest        = is_rtype ? rd : (is_addiu | is_lui | is_lw) ? rt : 5'd0;
    assign ds.br_taken       = to_es_valid && ds.es_allowin && br_cond;
    assign ds.br_target      = is_j ? {pc4[31:28], idx26, 2'b00} : (pc4 + br_offset);

    // Taking a new op whenever allowin is high also covers leave-and-arrive in one edge.
    always_comb begin
        ds_valid_d = ds_valid_q;
        ds_pc_d    = ds_pc_q;
        ds_inst_d  = ds_inst_q;
        if (allowin) begin
            ds_valid_d = ds.fs_to_ds_valid;
            if (ds.fs_to_ds_valid) begin
                ds_pc_d   = ds.fs_pc;
                ds_inst_d = ds.fs_inst;
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_valid_q <= 1'b0;
            ds_pc_q    <= 32'd0;
            ds_inst_q  <= 32'd0;
        end else begin
            ds_valid_q <= ds_valid_d;
            ds_pc_q    <= ds_pc_d;
            ds_inst_q  <= ds_inst_d;
        end
    end
endmodule

// File: tb/tb_id_stage.sv
// Bench for id_stage: directed scenarios plus randomized instructions and bypass traffic,
// checked against a mnemonic-level reference model and an in-order PC scoreboard.
`timescale 1ns/1ps
module tb_id_stage;
    typedef enum int {M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_SLT, M_SLL, M_ADDIU,
                      M_LUI, M_LW, M_SW, M_BEQ, M_BNE, M_J, M_NOP} mn_t;

    typedef struct {
        logic        to_es;
        logic        allowin;
        logic        br_taken;
        logic [3:0]  alu_op;
        logic [31:0] src1;
        logic [31:0] src2;
        logic [31:0] store;
        logic [31:0] target;
        logic        mem_re;
        logic        mem_we;
        logic [4:0]  dest;
        bit          chk_alu, chk_src1, chk_src2, chk_store, chk_target;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic resetn;
    always #5 clk = ~clk;

    id_stage_if bus ();
    id_stage dut (.clk(clk), .resetn(resetn), .ds(bus));

    // Register file read side, combinational like the real one.
    logic [31:0] rf [32];
    assign bus.rdata1 = rf[bus.raddr1];
    assign bus.rdata2 = rf[bus.raddr2];

    int errors = 0;
    int checks = 0;
    logic [31:0] exp_q [$];

    // Instruction currently expected to sit in decode.
    mn_t         cur_mn;
    logic [4:0]  cur_rs, cur_rt, cur_rd, cur_shamt;
    logic [15:0] cur_imm;
    logic [25:0] cur_idx;
    logic [31:0] cur_pc, cur_inst;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] encode(input mn_t mn, input logic [4:0] rs, input logic [4:0] rt,
                                           input logic [4:0] rd, input logic [4:0] sh,
                                           input logic [15:0] imm, input logic [25:0] idx);
        case (mn)
            M_ADDU:  return {6'h00, rs, rt, rd, 5'd0, 6'h21};
            M_SUBU:  return {6'h00, rs, rt, rd, 5'd0, 6'h23};
            M_AND:   return {6'h00, rs, rt, rd, 5'd0, 6'h24};
            M_OR:    return {6'h00, rs, rt, rd, 5'd0, 6'h25};
            M_XOR:   return {6'h00, rs, rt, rd, 5'd0, 6'h26};
            M_SLT:   return {6'h00, rs, rt, rd, 5'd0, 6'h2a};
            M_SLL:   return {6'h00, rs, rt, rd, sh, 6'h00};
            M_ADDIU: return {6'h09, rs, rt, imm};
            M_LUI:   return {6'h0f, rs, rt, imm};
            M_LW:    return {6'h23, rs, rt, imm};
            M_SW:    return {6'h2b, rs, rt, imm};
            M_BEQ:   return {6'h04, rs, rt, imm};
            M_BNE:   return {6'h05, rs, rt, imm};
            M_J:     return {6'h02, idx};
            default: return {6'h0d, rs, rt, imm};   // ORI: not supported, must act as NOP
        endcase
    endfunction

    task automatic set_op(input mn_t mn, input int rs, input int rt, input int rd, input int sh,
                          input logic [15:0] imm, input logic [25:0] idx, input logic [31:0] pc);
        cur_mn = mn; cur_rs = 5'(rs); cur_rt = 5'(rt); cur_rd = 5'(rd); cur_shamt = 5'(sh);
        cur_imm = imm; cur_idx = idx; cur_pc = pc;
        cur_inst = encode(mn, cur_rs, cur_rt, cur_rd, cur_shamt, imm, idx);
    endtask

    // ---------------- reference model ----------------
    function automatic logic [31:0] operand(input logic [4:0] r);
        if (r == 5'd0) return 32'd0;
        if (bus.es_fwd_valid && bus.es_fwd_dest == r) return bus.es_fwd_data;
        if (bus.ms_fwd_valid && bus.ms_fwd_dest == r) return bus.ms_fwd_data;
        if (bus.ws_fwd_valid && bus.ws_fwd_dest == r) return bus.ws_fwd_data;
        return rf[r];
    endfunction

    function automatic exp_t model();
        exp_t e;
        logic [31:0] a, b, sx, idxw;
        bit uses_rs, uses_rt, hazard, cond;
        a = operand(cur_rs);
        b = operand(cur_rt);
        sx = 32'($signed(cur_imm));
        idxw = {6'd0, cur_idx};
        uses_rs = 0; uses_rt = 0; cond = 0;
        e.alu_op = 4'd0; e.src1 = a; e.src2 = b; e.store = b; e.target = 32'd0;
        e.mem_re = 0; e.mem_we = 0; e.dest = 5'd0;
        e.chk_alu = 1; e.chk_src1 = 0; e.chk_src2 = 0; e.chk_store = 0; e.chk_target = 0;
        case (cur_mn)
            M_ADDU, M_SUBU, M_AND, M_OR, M_XOR, M_SLT: begin
                uses_rs = 1; uses_rt = 1; e.dest = cur_rd; e.chk_src1 = 1; e.chk_src2 = 1;
                e.alu_op = (cur_mn == M_ADDU) ? 4'd0 : (cur_mn == M_SUBU) ? 4'd1 :
                           (cur_mn == M_AND)  ? 4'd2 : (cur_mn == M_OR)   ? 4'd3 :
                           (cur_mn == M_XOR)  ? 4'd4 : 4'd5;
            end
            M_SLL: begin
                uses_rt = 1; e.alu_op = 4'd6; e.src1 = b; e.src2 = 32'(cur_shamt);
                e.dest = cur_rd; e.chk_src1 = 1; e.chk_src2 = 1;
            end
            M_ADDIU, M_LW, M_SW: begin
                uses_rs = 1; e.src2 = sx; e.chk_src1 = 1; e.chk_src2 = 1;
                if (cur_mn == M_SW) begin uses_rt = 1; e.mem_we = 1; e.chk_store = 1; end
                else e.dest = cur_rt;
                if (cur_mn == M_LW) e.mem_re = 1;
            end
            M_LUI: begin
                e.alu_op = 4'd7; e.src2 = 32'(cur_imm) << 16; e.dest = cur_rt; e.chk_src2 = 1;
            end
            M_BEQ, M_BNE: begin
                uses_rs = 1; uses_rt = 1; e.chk_alu = 0; e.chk_target = 1;
                cond = (cur_mn == M_BEQ) ? (a == b) : (a != b);
                e.target = cur_pc + 32'd4 + (sx << 2);
            end
            M_J: begin
                e.chk_alu = 0; e.chk_target = 1; cond = 1;
                e.target = ((cur_pc + 32'd4) & 32'hf000_0000) | (idxw << 2);
            end
            default: ;
        endcase
        hazard = bus.es_fwd_valid && bus.es_is_load && bus.es_fwd_dest != 5'd0 &&
                 ((uses_rs && bus.es_fwd_dest == cur_rs) || (uses_rt && bus.es_fwd_dest == cur_rt));
        e.to_es    = !hazard;
        e.allowin  = !hazard && bus.es_allowin;
        e.br_taken = e.to_es && bus.es_allowin && cond;
        return e;
    endfunction

    task automatic check_outputs(input string tag, input exp_t e);
        check_eq({tag, "_to_es"},   32'(bus.ds_to_es_valid), 32'(e.to_es));
        check_eq({tag, "_allowin"}, 32'(bus.ds_allowin),     32'(e.allowin));
        check_eq({tag, "_br"},      32'(bus.br_taken),       32'(e.br_taken));
        check_eq({tag, "_pc"},      bus.ds_pc,               cur_pc);
        check_eq({tag, "_mem"},     32'({bus.ds_mem_re, bus.ds_mem_we}), 32'({e.mem_re, e.mem_we}));
        check_eq({tag, "_dest"},    32'(bus.ds_dest),        32'(e.dest));
        if (e.chk_target) check_eq({tag, "_target"}, bus.br_target, e.target);
        if (e.to_es) begin
            if (e.chk_alu)   check_eq({tag, "_alu"},   32'(bus.ds_alu_op), 32'(e.alu_op));
            if (e.chk_src1)  check_eq({tag, "_src1"},  bus.ds_src1, e.src1);
            if (e.chk_src2)  check_eq({tag, "_src2"},  bus.ds_src2, e.src2);
            if (e.chk_store) check_eq({tag, "_store"}, bus.ds_store_data, e.store);
        end
    endtask

    // Scoreboard: the op leaving decode must be the oldest one accepted.
    task automatic sb_pop(input string tag);
        if (exp_q.size() == 0) check_eq({tag, "_sb_underflow"}, 32'd0, 32'd1);
        else check_eq({tag, "_sb_pc"}, bus.ds_pc, exp_q.pop_front());
    endtask

    // ---------------- driver tasks ----------------
    task automatic idle_bus();
        bus.es_fwd_valid = 0; bus.es_fwd_dest = 0; bus.es_fwd_data = 0; bus.es_is_load = 0;
        bus.ms_fwd_valid = 0; bus.ms_fwd_dest = 0; bus.ms_fwd_data = 0;
        bus.ws_fwd_valid = 0; bus.ws_fwd_dest = 0; bus.ws_fwd_data = 0;
        bus.es_allowin = 1;
    endtask

    task automatic rand_bus();
        bus.es_fwd_valid = 1'($urandom_range(0, 1)); bus.es_fwd_dest = 5'($urandom_range(0, 7));
        bus.es_fwd_data = $urandom; bus.es_is_load = ($urandom_range(0, 2) == 0);
        bus.ms_fwd_valid = 1'($urandom_range(0, 1)); bus.ms_fwd_dest = 5'($urandom_range(0, 7));
        bus.ms_fwd_data = $urandom;
        bus.ws_fwd_valid = 1'($urandom_range(0, 1)); bus.ws_fwd_dest = 5'($urandom_range(0, 7));
        bus.ws_fwd_data = $urandom;
        bus.es_allowin = ($urandom_range(0, 3) != 0);
    endtask

    // Offer cur_inst with decode guaranteed free; returns at the next negedge with it held.
    task automatic issue_op();
        @(negedge clk);
        idle_bus();
        bus.fs_to_ds_valid = 1; bus.fs_pc = cur_pc; bus.fs_inst = cur_inst;
        exp_q.push_back(cur_pc);
        @(posedge clk);
        @(negedge clk);
        bus.fs_to_ds_valid = 0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        exp_t e;
        logic [31:0] next_inst;
        for (int i = 0; i < 32; i++) rf[i] = $urandom;
        rf[0] = 32'hdead_0000;
        bus.fs_to_ds_valid = 0; bus.fs_pc = 0; bus.fs_inst = 0;
        idle_bus();
        resetn = 0;
        #1;
        check_eq("rst_to_es",   32'(bus.ds_to_es_valid), 32'd0);
        check_eq("rst_allowin", 32'(bus.ds_allowin),     32'd1);
        check_eq("rst_br",      32'(bus.br_taken),       32'd0);
        check_eq("rst_mem",     32'({bus.ds_mem_re, bus.ds_mem_we}), 32'd0);
        check_eq("rst_dest",    32'(bus.ds_dest),        32'd0);
        check_eq("rst_pc",      bus.ds_pc,               32'd0);
        @(negedge clk); @(negedge clk);
        resetn = 1;

        // ADDU $3,$1,$2 with $2 bypassed from EX
        rf[1] = 32'd5;
        set_op(M_ADDU, 1, 2, 3, 0, 16'h0, 26'h0, 32'h40);
        issue_op();
        bus.es_fwd_valid = 1; bus.es_fwd_dest = 5'd2; bus.es_fwd_data = 32'd7;
        #1;
        check_eq("addu_src1", bus.ds_src1, 32'd5);
        check_eq("addu_src2", bus.ds_src2, 32'd7);
        check_eq("addu_alu",  32'(bus.ds_alu_op), 32'd0);
        check_eq("addu_dest", 32'(bus.ds_dest),   32'd3);
        check_outputs("addu", model());
        sb_pop("addu");

        // Load-use: LW $4 in EX, ADDU $5,$4,$4 in decode
        set_op(M_ADDU, 4, 4, 5, 0, 16'h0, 26'h0, 32'h44);
        issue_op();
        bus.es_fwd_valid = 1; bus.es_fwd_dest = 5'd4; bus.es_fwd_data = 32'hbad0_bad0; bus.es_is_load = 1;
        #1;
        check_eq("lu_stall_to_es",   32'(bus.ds_to_es_valid), 32'd0);
        check_eq("lu_stall_allowin", 32'(bus.ds_allowin),     32'd0);
        check_outputs("lu_stall", model());
        @(negedge clk);
        idle_bus();
        bus.ms_fwd_valid = 1; bus.ms_fwd_dest = 5'd4; bus.ms_fwd_data = 32'h1234_5678;
        #1;
        check_eq("lu_go_to_es", 32'(bus.ds_to_es_valid), 32'd1);
        check_eq("lu_go_src1",  bus.ds_src1, 32'h1234_5678);
        check_eq("lu_go_src2",  bus.ds_src2, 32'h1234_5678);
        check_outputs("lu_go", model());
        sb_pop("lu_go");

        // BEQ at 0x100, imm 4: equal then unequal operands
        rf[1] = 32'h55; rf[2] = 32'h55;
        set_op(M_BEQ, 1, 2, 0, 0, 16'h0004, 26'h0, 32'h100);
        issue_op();
        #1;
        check_eq("beq_eq_taken",  32'(bus.br_taken), 32'd1);
        check_eq("beq_eq_target", bus.br_target,     32'h114);
        check_outputs("beq_eq", model());
        sb_pop("beq_eq");
        rf[2] = 32'h56;
        set_op(M_BEQ, 1, 2, 0, 0, 16'h0004, 26'h0, 32'h100);
        issue_op();
        #1;
        check_eq("beq_ne_taken", 32'(bus.br_taken), 32'd0);
        check_outputs("beq_ne", model());
        sb_pop("beq_ne");

        // EX back-pressure for 3 cycles on a held XOR while fetch keeps offering
        set_op(M_XOR, 1, 2, 7, 0, 16'h0, 26'h0, 32'h1f0);
        issue_op();
        next_inst = encode(M_ADDU, 5'd3, 5'd1, 5'd9, 5'd0, 16'h0, 26'h0);
        bus.es_allowin = 0;
        bus.fs_to_ds_valid = 1; bus.fs_pc = 32'h200; bus.fs_inst = next_inst;
        for (int c = 0; c < 3; c++) begin
            #1;
            check_eq("hold_allowin", 32'(bus.ds_allowin), 32'd0);
            check_outputs("hold", model());
            @(negedge clk);
        end
        bus.es_allowin = 1;
        #1;
        check_outputs("release", model());
        sb_pop("release");
        exp_q.push_back(32'h200);
        @(negedge clk);
        bus.fs_to_ds_valid = 0;
        set_op(M_ADDU, 3, 1, 9, 0, 16'h0, 26'h0, 32'h200);
        #1;
        check_outputs("arrive", model());
        sb_pop("arrive");

        // $0 on every bypass bus, including a load in EX
        set_op(M_ADDU, 0, 0, 6, 0, 16'h0, 26'h0, 32'h300);
        issue_op();
        bus.es_fwd_valid = 1; bus.es_fwd_dest = 0; bus.es_fwd_data = 32'h11; bus.es_is_load = 1;
        bus.ms_fwd_valid = 1; bus.ms_fwd_dest = 0; bus.ms_fwd_data = 32'h22;
        bus.ws_fwd_valid = 1; bus.ws_fwd_dest = 0; bus.ws_fwd_data = 32'h33;
        #1;
        check_eq("zero_src1",  bus.ds_src1, 32'd0);
        check_eq("zero_src2",  bus.ds_src2, 32'd0);
        check_eq("zero_to_es", 32'(bus.ds_to_es_valid), 32'd1);
        check_outputs("zero", model());
        sb_pop("zero");

        // Reset between clock edges while an op is held by EX back-pressure
        set_op(M_LW, 1, 8, 0, 0, 16'h0010, 26'h0, 32'h400);
        issue_op();
        bus.es_allowin = 0;
        #2;
        resetn = 0;
        #1;
        check_eq("midrst_to_es",   32'(bus.ds_to_es_valid), 32'd0);
        check_eq("midrst_allowin", 32'(bus.ds_allowin),     32'd1);
        check_eq("midrst_mem",     32'({bus.ds_mem_re, bus.ds_mem_we}), 32'd0);
        exp_q.delete();
        @(negedge clk);
        resetn = 1;
        idle_bus();

        // Randomized instruction mix against random bypass traffic
        for (int n = 0; n < 400; n++) begin
            set_op(mn_t'($urandom_range(0, 14)), $urandom_range(0, 7), $urandom_range(0, 7),
                   $urandom_range(0, 7), $urandom_range(0, 31), 16'($urandom), 26'($urandom),
                   $urandom & 32'hffff_fffc);
            for (int i = 1; i < 8; i++) rf[i] = $urandom;
            issue_op();
            rand_bus();
            #1;
            e = model();
            check_outputs("rnd", e);
            if (e.to_es && bus.es_allowin) begin
                sb_pop("rnd");
            end else begin
                @(negedge clk);
                rand_bus();
                bus.es_is_load = 0; bus.es_allowin = 1;
                #1;
                check_outputs("rnd2", model());
                sb_pop("rnd2");
            end
        end
        @(negedge clk);
        check_eq("sb_left", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule
